// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the byte-serial memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAST  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [2:0] byte_count(input logic is_fetch, input logic [1:0] size);
    logic [2:0] n;
    if (is_fetch) n = 3'd4;
    else begin
      case (size)
        SZ_BYTE: n = 3'd1;
        SZ_HALF: n = 3'd2;
        default: n = 3'd4;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extender.sv
// Right-justifies an N-byte big-endian read value (assembled from bit 31 down)
// and sign- or zero-extends it to 32 bits.
module load_extender
  import mem_seq_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{is_signed & raw[31]}}, raw[31:24]};
      SZ_HALF: ext = {{16{is_signed & raw[31]}}, raw[31:16]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Serialises instruction fetches and load/store accesses onto one byte-wide memory.
// Build option: define ALIGN_CHECK_EN to fault misaligned requests instead of serving them.
//
// state | meaning
// IDLE  | sample requests, data has priority over fetch
// ISSUE | one memory byte access per cycle, cnt = 0..N-1
// LAST  | capture the final read byte (reads only)
// ACK   | one-cycle completion pulse
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_instr,
  output logic              pc_write,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              addr_fault,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state, state_nx;
  logic              is_fetch_q, we_q, signed_q, fault_q;
  logic [1:0]        size_q, cnt;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, ext_c;
  logic [3:0][7:0]   rbuf, asm_c, wshift;
  logic              accept, misalign_c, last_issue, issue_act;
  logic [1:0]        sel_size, sel_lo;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

  assign accept     = (state == IDLE) && (d_req || if_req);
  assign sel_size   = d_req ? d_size : SZ_WORD;
  assign sel_lo     = d_req ? d_addr[1:0] : if_addr[1:0];
  assign last_issue = ({1'b0, cnt} == (n_q - 3'd1));

`ifdef ALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    case (sel_size)
      SZ_BYTE: misalign_c = 1'b0;
      SZ_HALF: misalign_c = sel_lo[0];
      default: misalign_c = |sel_lo;
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (d_req || if_req) state_nx = misalign_c ? ACK : ISSUE;
      ISSUE:   if (last_issue) state_nx = we_q ? ACK : LAST;
      LAST:    state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte k of the access lands in rbuf[3-k]; each byte arrives one cycle after its issue.
  always_comb begin
    asm_c = rbuf;
    if (state == ISSUE && cnt != 2'd0 && !we_q)
      asm_c[2'd3 - (cnt - 2'd1)] = mem_rdata;
    else if (state == LAST)
      asm_c[2'd3 - cnt] = mem_rdata;
  end

  load_extender u_ext (
    .raw      (asm_c),
    .size     (size_q),
    .is_signed(signed_q),
    .ext      (ext_c)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      is_fetch_q <= 1'b0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      n_q        <= 3'd0;
      cnt        <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf       <= '0;
      if_instr   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_fetch_q <= !d_req;
          we_q       <= d_req & d_we;
          signed_q   <= d_req & d_signed;
          size_q     <= sel_size;
          n_q        <= byte_count(!d_req, d_size);
          addr_q     <= d_req ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          wdata_q    <= d_wdata;
          fault_q    <= misalign_c;
          cnt        <= 2'd0;
          rbuf       <= '0;
          if (misalign_c) begin
            if (!d_req)     if_instr <= '0;
            else if (!d_we) d_rdata  <= '0;
          end
        end
        ISSUE: begin
          rbuf <= asm_c;
          if (!last_issue) cnt <= cnt + 2'd1;
        end
        LAST: begin
          if (is_fetch_q) if_instr <= ext_c;
          else            d_rdata  <= ext_c;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (n_q)
      3'd1:    wshift = {wdata_q[7:0], 24'h0};
      3'd2:    wshift = {wdata_q[15:0], 16'h0};
      default: wshift = wdata_q;
    endcase
  end

  // Strobes are gated by reset so an aborted store writes nothing in the reset cycle.
  assign issue_act  = (state == ISSUE) && !reset;
  assign mem_en     = issue_act;
  assign mem_we     = issue_act & we_q;
  assign mem_addr   = issue_act ? addr_q + ADDR_W'(cnt) : '0;
  assign mem_wdata  = mem_we ? wshift[2'd3 - cnt] : 8'h00;

  assign if_ack     = (state == ACK) &  is_fetch_q;
  assign d_ack      = (state == ACK) & !is_fetch_q;
  assign pc_write   = if_ack;
  assign addr_fault = (state == ACK) & fault_q;
  assign busy       = (state != IDLE);

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Shares one byte-wide, 512-byte, synchronous-read memory between instruction fetch and load/store data accesses. It serialises each 32-bit fetch or byte/half/word data access into consecutive big-endian byte transfers and assembles or extends read data. It arbitrates fetch against data, and gates program-counter advance with a completion pulse. It sits between the program counter / instruction path, the load/store path, and the shared byte memory.

## Interface
- ADDR_W, 9, memory byte-address width (512 bytes)
- Clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address
- if_ack  out  1  one-cycle fetch completion pulse
- if_instr  out  32  fetched instruction; valid with if_ack, held until the next if_ack
- pc_write  out  1  equals if_ack; drives ProgramCounter PCWrite
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- d_signed  in  1  sign-extend byte/half loads (0 = zero-extend)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data; valid with d_ack, held until the next load d_ack
- addr_fault  out  1  misaligned access; valid with the ack pulse
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid in the cycle after mem_en with mem_we = 0

## Operation
- States: IDLE, ISSUE, LAST, ACK.
- IDLE samples requests. If both are present, data wins, because the load/store belongs to the older instruction. The accepted address, size, we, signed flag and wdata are latched.
- Byte count N: fetch 4; word 4; half 2; byte 1.
- ISSUE lasts N cycles. Counter cnt runs 0..N-1. mem_addr = (addr + cnt) mod 2^ADDR_W; the upper address bits are ignored and the address wraps silently.
- Byte order is big-endian: the byte at addr + k maps to bit [31-8k -: 8] of the N-byte value.
- Stores write the low N bytes of d_wdata, most significant first. For example, a half write puts d_wdata[15:8] at addr and d_wdata[7:0] at addr+1.
- Reads capture the returning byte each cycle.
  - ISSUE → LAST after the final issue for reads.
  - ISSUE → ACK directly for writes.
- LAST captures the final byte, then goes to ACK.
- ACK pulses if_ack or d_ack for exactly one cycle, then returns to IDLE.
- Byte/half loads are sign- or zero-extended to 32 bits per d_signed.
- A requester must deassert req in the cycle after its ack unless it is issuing a new request. A req still high in that cycle is a new request.
- mem_en and mem_we are 0 outside ISSUE. mem_wdata is 0 when not writing.
- Reset value of every output is 0.
- Reset mid-operation: return to IDLE the next cycle with no ack. Bytes already written stay written.

## Timing
- Request accepted in IDLE at cycle T.
- ISSUE occupies cycles T+1..T+N.
- Read ack: cycle T+N+2. Fetch and word loads ack at T+6; byte loads at T+3.
- Write ack: cycle T+N+1. Word stores ack at T+5.
- Earliest next acceptance is the cycle after ack.
- Maximum throughput is one fetch per 7 cycles.
- A request arriving while busy waits with no loss. A data request pending at fetch-ack time is served before the next fetch.

## Configuration
- ALIGN_CHECK_EN defined:
  - Misaligned requests are faulted: fetch or word with addr[1:0] ≠ 0, half with addr[0] ≠ 0.
  - A faulted request goes IDLE → ACK with no memory access: ack at T+1, addr_fault = 1, read data 0.
- Without ALIGN_CHECK_EN:
  - addr_fault is tied to 0.
  - Misaligned accesses proceed byte by byte per Operation.

## Structure
- Package mem_seq_pkg holds:
  - the state enum
  - d_size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the byte-count function from size/fetch
- Sub-module load_extender: combinational N-byte right-justify plus sign/zero extension of the assembled read value.

## Test plan
- Fetch from 0x000, memory 24 01 00 2C, at T → if_instr = 0x2401002C and if_ack = pc_write = 1 at exactly T+6. mem_addr sequence 0, 1, 2, 3.
- Simultaneous d_req (LB signed at 0x021 = 0x90) and if_req → data served first. d_rdata = 0xFFFFFF90 at T+3, then the fetch is accepted at T+4.
- SH of d_wdata = 0x0000ABCD to 0x010 → bytes AB@0x010, CD@0x011, d_ack at T+3. A following LHU from 0x010 returns 0x0000ABCD.
- Fetch at 0x1FE → mem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001 (wrap). With ALIGN_CHECK_EN instead: ack at T+1, addr_fault = 1, mem_en never asserted.
- Reset asserted in the second ISSUE cycle of an SW → next cycle IDLE, all outputs 0, no d_ack. Exactly one byte is written.
